// File: rtl/ts_stream_arbiter_pkg.sv
// rtl/ts_stream_arbiter_pkg.sv - shared constants, state encoding and null-packet byte table
package ts_stream_arbiter_pkg;

  localparam logic [7:0]  TS_SYNC     = 8'h47;
  localparam logic [12:0] NULL_PID    = 13'h1FFF;
  localparam logic [7:0]  NULL_HDR3   = 8'h10;
  localparam logic [7:0]  NULL_FILL   = 8'hFF;
  localparam int          PKT_LEN_DEF = 188;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    SEND_CH   = 2'd1,
    SEND_NULL = 2'd2
  } arb_state_t;

  // Header: sync, PID high bits with flags clear, PID low bits, payload-only/CC 0; then stuffing.
  function automatic logic [7:0] null_byte(input logic [7:0] b);
    case (b)
      8'd0:    null_byte = TS_SYNC;
      8'd1:    null_byte = {3'b000, NULL_PID[12:8]};
      8'd2:    null_byte = NULL_PID[7:0];
      8'd3:    null_byte = NULL_HDR3;
      default: null_byte = NULL_FILL;
    endcase
  endfunction

endpackage

// File: rtl/ts_stream_arbiter_if.sv
// rtl/ts_stream_arbiter_if.sv - channel request/pop side and TS output bus of the arbiter
interface ts_stream_arbiter_if #(
  parameter int N_CH = 4,
  parameter int CW   = 2
);
  logic [N_CH-1:0]   in_req;
  logic [8*N_CH-1:0] in_data;
  logic [N_CH-1:0]   in_rd;

  logic [7:0]        data;
  logic              d_clk;
  logic              d_valid;
  logic              p_sync;
  logic [CW-1:0]     ch_id;
  logic              null_pkt;
  logic [N_CH-1:0]   sync_err;
  logic              busy;

  modport master (
    input  in_req, in_data,
    output in_rd, data, d_clk, d_valid, p_sync, ch_id, null_pkt, sync_err, busy
  );

  modport slave (
    output in_req, in_data,
    input  in_rd, data, d_clk, d_valid, p_sync, ch_id, null_pkt, sync_err, busy
  );
endinterface

// File: rtl/ts_stream_arbiter_rr_picker.sv
// rtl/ts_stream_arbiter_rr_picker.sv - combinational round-robin search from ptr upward with wrap
module rr_picker #(
  parameter int N_CH = 4,
  parameter int CW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic            found,
  output logic [CW-1:0]   idx
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [CW:0]       sum;

  // Rotating a doubled copy puts channel ptr at bit 0, so the first set bit is the winner.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_CH-1:0];
    found = 1'b0;
    sum   = '0;
    idx   = ptr;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (CW+1)'(i);
        if (sum >= (CW+1)'(N_CH)) begin
          sum = sum - (CW+1)'(N_CH);
        end
        idx = sum[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/ts_stream_arbiter.sv
// rtl/ts_stream_arbiter.sv - packet-granular round-robin TS arbiter with optional null-packet fill
module ts_stream_arbiter
  import ts_stream_arbiter_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int PKT_LEN = PKT_LEN_DEF,
  parameter int NULL_EN = 1,
  parameter int CW      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ts_stream_arbiter_if.master  bus
);

  arb_state_t      state;
  logic [7:0]      byte_cnt;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   grant;
  logic            pick_found;
  logic [CW-1:0]   pick_idx;
  logic [7:0]      head;
  logic            first_byte;
  logic            last_byte;

  rr_picker #(.N_CH(N_CH), .CW(CW)) u_rr_picker (
    .req   (bus.in_req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    head = 8'h00;
    for (int k = 0; k < N_CH; k++) begin
      if (grant == CW'(k)) begin
        head = bus.in_data[8*k +: 8];
      end
    end
  end

  assign first_byte = (byte_cnt == 8'd0);
  assign last_byte  = (byte_cnt == 8'(PKT_LEN-1));

  // Pop is a decode of registered state so the FIFO sees it a full cycle before the data edge.
  always_comb begin
    bus.in_rd = '0;
    if (state == SEND_CH) begin
      bus.in_rd[grant] = 1'b1;
    end
  end

  assign bus.d_clk = clk;
  assign bus.busy  = (state != ARB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB;
      byte_cnt     <= 8'd0;
      rr_ptr       <= '0;
      grant        <= '0;
      bus.data     <= 8'h00;
      bus.d_valid  <= 1'b0;
      bus.p_sync   <= 1'b0;
      bus.ch_id    <= '0;
      bus.null_pkt <= 1'b0;
      bus.sync_err <= '0;
    end else begin
      bus.sync_err <= '0;
      case (state)
        ARB: begin
          bus.d_valid  <= 1'b0;
          bus.p_sync   <= 1'b0;
          bus.data     <= 8'h00;
          bus.null_pkt <= 1'b0;
          byte_cnt     <= 8'd0;
          if (pick_found) begin
            grant  <= pick_idx;
            rr_ptr <= (pick_idx == CW'(N_CH-1)) ? '0 : pick_idx + CW'(1);
            state  <= SEND_CH;
          end else if (NULL_EN != 0) begin
            state <= SEND_NULL;
          end
        end

        SEND_CH: begin
          bus.d_valid  <= 1'b1;
          bus.ch_id    <= grant;
          bus.p_sync   <= first_byte;
          bus.null_pkt <= 1'b0;
          // A corrupt sync byte is repaired on the wire and flagged against its source.
          bus.data     <= first_byte ? TS_SYNC : head;
          if (first_byte && (head != TS_SYNC)) begin
            bus.sync_err[grant] <= 1'b1;
          end
          if (last_byte) begin
            byte_cnt <= 8'd0;
            state    <= ARB;
          end else begin
            byte_cnt <= byte_cnt + 8'd1;
          end
        end

        SEND_NULL: begin
          bus.d_valid  <= 1'b1;
          bus.ch_id    <= grant;
          bus.p_sync   <= first_byte;
          bus.null_pkt <= 1'b1;
          bus.data     <= null_byte(byte_cnt);
          if (last_byte) begin
            byte_cnt <= 8'd0;
            state    <= ARB;
          end else begin
            byte_cnt <= byte_cnt + 8'd1;
          end
        end

        default: begin
          byte_cnt <= 8'd0;
          state    <= ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_stream_arbiter.sv
// tb/tb_ts_stream_arbiter.sv - self-checking bench for ts_stream_arbiter
module tb_ts_stream_arbiter;

  localparam int N  = 4;
  localparam int PL = 188;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ts_stream_arbiter_if #(.N_CH(N), .CW(2)) bus ();
  ts_stream_arbiter_if #(.N_CH(N), .CW(2)) busz ();

  ts_stream_arbiter #(.N_CH(N), .PKT_LEN(PL), .NULL_EN(1), .CW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  ts_stream_arbiter #(.N_CH(N), .PKT_LEN(PL), .NULL_EN(0), .CW(2)) dutz (
    .clk (clk),
    .rst (rst),
    .bus (busz.master)
  );

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       psync;
    logic [1:0] ch;
    logic       nul;
    logic [3:0] serr;
    logic [3:0] rd;
    logic       busy;
  } rec_t;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] first;
    int         ech;
    logic       enull;
    logic [3:0] eserr;
  } row_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int next_arb = 0;
  int mptr = 0;
  int mgrant = 0;
  int mlast_ch = 0;
  logic rand_on = 1'b0;
  logic [3:0] req_en = 4'b0;
  logic [3:0] req_now = 4'b0;
  logic [3:0] rd_prev = 4'b0;
  logic [7:0] fq[N][$];
  rec_t exp_q[$];
  row_t rows[10];
  int fair[5];

  logic [7:0] obs_data;
  logic       obs_psync;
  logic [1:0] obs_ch;
  logic       obs_null;
  logic [3:0] obs_serr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] null_ref(input int b);
    case (b)
      0:       return 8'h47;
      1:       return 8'h1F;
      2:       return 8'hFF;
      3:       return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic add_pkt(input int k, input logic [7:0] first);
    fq[k].push_back(first);
    for (int b = 1; b < PL; b++) fq[k].push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic clear_fifos();
    for (int k = 0; k < N; k++) fq[k].delete();
    rd_prev = 4'b0;
  endtask

  task automatic drive();
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < N; k++) begin
      req_now[k] = req_en[k] && (fq[k].size() >= PL);
      if (fq[k].size() > 0) d[8*k +: 8] = fq[k][0];
    end
    bus.in_req  = req_now;
    bus.in_data = d;
  endtask

  // One arbitration: the gap cycle plus a whole packet is known the moment a winner is chosen.
  task automatic decide();
    int g;
    rec_t r;
    logic [3:0] oh;
    logic [7:0] bv;
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && req_now[(mptr + i) % N]) g = (mptr + i) % N;
    if (g >= 0) begin
      mgrant = g;
      mptr = (g + 1) % N;
      oh = 4'(1 << g);
    end else begin
      oh = 4'b0;
    end
    r = '0; r.ch = 2'(mlast_ch); r.rd = oh; r.busy = 1'b1;
    exp_q.push_back(r);
    for (int b = 0; b < PL; b++) begin
      r = '0;
      r.valid = 1'b1;
      r.psync = (b == 0);
      r.ch = 2'(mgrant);
      r.nul = (g < 0);
      if (g >= 0) begin
        bv = fq[g][b];
        r.data = (b == 0) ? 8'h47 : bv;
        if (b == 0 && bv != 8'h47) r.serr = oh;
      end else begin
        r.data = null_ref(b);
      end
      r.rd = (b < PL-1) ? oh : 4'b0;
      r.busy = (b < PL-1);
      exp_q.push_back(r);
    end
    mlast_ch = mgrant;
    next_arb = cyc + PL + 1;
  endtask

  task automatic tick_body();
    rec_t e;
    for (int k = 0; k < N; k++)
      if (rd_prev[k] && fq[k].size() > 0) void'(fq[k].pop_front());
    if (rand_on) begin
      for (int k = 0; k < N; k++)
        if (fq[k].size() < 2*PL && $urandom_range(0, 99) == 0)
          add_pkt(k, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'h47);
      if ($urandom_range(0, 199) == 0) begin
        int j;
        j = int'($urandom_range(0, N-1));
        req_en[j] = ~req_en[j];
      end
    end
    drive();
    obs_data  = bus.data;
    obs_psync = bus.p_sync;
    obs_ch    = bus.ch_id;
    obs_null  = bus.null_pkt;
    obs_serr  = bus.sync_err;
    if (exp_q.size() == 0) begin
      chk("exp_queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("d_valid", bus.d_valid, e.valid);
      chk("data", bus.data, e.data);
      chk("p_sync", bus.p_sync, e.psync);
      chk("ch_id", bus.ch_id, e.ch);
      chk("null_pkt", bus.null_pkt, e.nul);
      chk("sync_err", bus.sync_err, e.serr);
      chk("in_rd", bus.in_rd, e.rd);
      chk("busy", bus.busy, e.busy);
    end
    chk("in_rd_onehot", $onehot0(bus.in_rd), 1);
    chk("d_clk_low", bus.d_clk, 0);
    chk("z_idle_valid", busz.d_valid, 0);
    chk("z_idle_rd", busz.in_rd, 0);
    rd_prev = bus.in_rd;
    if (cyc == next_arb) decide();
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    tick_body();
  endtask

  task automatic run_until_arb();
    int guard;
    guard = 0;
    while (cyc != next_arb && guard < PL + 5) begin
      cycle();
      guard++;
    end
    chk("arb_reached", (cyc == next_arb), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, bus.data, 0);
    chk({tag, "_valid"}, bus.d_valid, 0);
    chk({tag, "_psync"}, bus.p_sync, 0);
    chk({tag, "_ch"}, bus.ch_id, 0);
    chk({tag, "_null"}, bus.null_pkt, 0);
    chk({tag, "_serr"}, bus.sync_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_rd"}, bus.in_rd, 0);
  endtask

  // Release reset on a falling edge; the first rising edge afterwards is an arbitration.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back('0);
    mptr = 0; mgrant = 0; mlast_ch = 0;
    next_arb = cyc;
    rd_prev = 4'b0;
    tick_body();
  endtask

  initial begin
    rows[0] = '{4'b0000, 8'h47, 0, 1'b1, 4'b0000};
    rows[1] = '{4'b0100, 8'h47, 2, 1'b0, 4'b0000};
    rows[2] = '{4'b1111, 8'h47, 3, 1'b0, 4'b0000};
    rows[3] = '{4'b1111, 8'h47, 0, 1'b0, 4'b0000};
    rows[4] = '{4'b0001, 8'h00, 0, 1'b0, 4'b0001};
    rows[5] = '{4'b0011, 8'h47, 1, 1'b0, 4'b0000};
    rows[6] = '{4'b0001, 8'h47, 0, 1'b0, 4'b0000};
    rows[7] = '{4'b0000, 8'h47, 0, 1'b1, 4'b0000};
    rows[8] = '{4'b1000, 8'h12, 3, 1'b0, 4'b1000};
    rows[9] = '{4'b0000, 8'h47, 3, 1'b1, 4'b0000};
    fair = '{0, 1, 2, 3, 0};

    bus.in_req = '0; bus.in_data = '0;
    busz.in_req = '0; busz.in_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("init_rst");
    clear_fifos();
    req_en = 4'b0;
    do_reset();

    for (int r = 0; r < 10; r++) begin
      run_until_arb();
      clear_fifos();
      for (int k = 0; k < N; k++) if (rows[r].mask[k]) add_pkt(k, rows[r].first);
      req_en = rows[r].mask;
      repeat (3) cycle();
      chk("row_ch", obs_ch, rows[r].ech);
      chk("row_null", obs_null, rows[r].enull);
      chk("row_serr", obs_serr, rows[r].eserr);
      chk("row_sync_byte", obs_data, 8'h47);
      chk("row_psync", obs_psync, 1);
    end

    run_until_arb();
    clear_fifos();
    add_pkt(3, 8'h47);
    req_en = 4'b1000;
    repeat (103) cycle();
    chk("pre_rst_ch", obs_ch, 3);
    chk("pre_rst_valid", bus.d_valid, 1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    clear_fifos();
    for (int k = 0; k < N; k++) begin
      add_pkt(k, 8'h47);
      add_pkt(k, 8'h47);
    end
    req_en = 4'b1111;
    do_reset();
    repeat (2) cycle();
    chk("fair_0", obs_ch, fair[0]);
    for (int p = 1; p < 5; p++) begin
      run_until_arb();
      repeat (3) cycle();
      chk("fair_seq", obs_ch, fair[p]);
    end

    rand_on = 1'b1;
    repeat (6000) cycle();
    rand_on = 1'b0;

    @(negedge clk);
    busz.in_data = {8'h00, 8'h00, 8'h47, 8'h00};
    busz.in_req = 4'b0010;
    @(negedge clk);
    chk("z_rd_after_req", busz.in_rd, 4'b0010);
    chk("z_gap_valid", busz.d_valid, 0);
    chk("z_busy", busz.busy, 1);
    @(negedge clk);
    chk("z_first_valid", busz.d_valid, 1);
    chk("z_first_psync", busz.p_sync, 1);
    chk("z_first_ch", busz.ch_id, 1);
    chk("z_first_data", busz.data, 8'h47);
    chk("z_first_null", busz.null_pkt, 0);
    busz.in_req = 4'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ts_stream_arbiter.md
Name: ts_stream_arbiter

Overview:
Shares one serial-parallel TS output between N_CH requesting channels (tuner front-ends, each behind a first-word-fall-through packet FIFO). Arbitrates round-robin at packet granularity, so a 188-byte packet is never interleaved. When no channel has a full packet ready, it optionally emits null packets (PID 0x1FFF) to keep the output stream continuous. The output matches the codebase TS bus (DATA/D_CLK/D_VALID/P_SYNC) and feeds the downstream TS sink or test port.

Parameters:
N_CH, 4, number of requesting channels (2..8)
PKT_LEN, 188, bytes per TS packet
NULL_EN, 1, 1 = insert null packets when idle; 0 = hold D_VALID low when idle
CW, 2, width of CH_ID (ceil log2 N_CH)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  asynchronous, active-low reset
IN_REQ  in  N_CH  per channel: FIFO holds at least one complete packet
IN_DATA  in  8*N_CH  per channel FWFT head byte; channel k occupies [8k+7:8k]
IN_RD  out  N_CH  per channel pop strobe; combinational from registered state
DATA  out  8  output TS byte
D_CLK  out  1  equals CLK
D_VALID  out  1  DATA qualifier
P_SYNC  out  1  high on the sync byte of each packet
CH_ID  out  CW  source channel of the current byte; N_CH-1 is not reserved, and null packets report the last granted channel
NULL_PKT  out  1  high on every byte of an inserted null packet
SYNC_ERR  out  N_CH  one-cycle pulse: granted channel's first byte was not 0x47
BUSY  out  1  high in SEND_CH or SEND_NULL

Behaviour:
- Reset (async, RST=0): state=ARB, byte_cnt=0, rr_ptr=0, grant=0. DATA=0, D_VALID=0, P_SYNC=0, CH_ID=0, NULL_PKT=0, SYNC_ERR=0, BUSY=0, IN_RD=0.
- State ARB (one cycle):
  - Sample IN_REQ and search from rr_ptr upward, with wrap.
  - If channel g is found: grant<=g, rr_ptr<=g+1 mod N_CH, go to SEND_CH.
  - Else if NULL_EN: go to SEND_NULL.
  - Else stay in ARB.
  - Outputs in this cycle: D_VALID<=0, P_SYNC<=0, DATA<=0, NULL_PKT<=0.
- State SEND_CH, byte_cnt b = 0..PKT_LEN-1:
  - IN_RD[grant]=1 every cycle; all other IN_RD bits are 0.
  - Registered outputs, one cycle after each pop: D_VALID<=1, CH_ID<=grant, P_SYNC<=(b==0).
  - DATA<=(b==0) ? 8'h47 : IN_DATA[grant]. The sync byte is always forced to 0x47.
  - If b==0 and IN_DATA[grant]!=8'h47: SYNC_ERR[grant] pulses in the same cycle as P_SYNC.
  - At b==PKT_LEN-1: byte_cnt<=0, go to ARB.
- State SEND_NULL, b = 0..PKT_LEN-1:
  - No IN_RD asserted. NULL_PKT<=1, D_VALID<=1, P_SYNC<=(b==0).
  - DATA by byte: b0=0x47, b1=0x1F, b2=0xFF, b3=0x10, rest=0xFF.
  - At b==PKT_LEN-1: go to ARB.
- Packet period = PKT_LEN+1 cycles, including one ARB gap cycle.
- IN_REQ is sampled only in ARB. Deassertion mid-packet is an upstream violation and is ignored; the packet completes.
- A request arriving during SEND_NULL waits for the null packet to finish.
- Fairness: with all channels requesting, grant order is 0,1,2,3,0,...
- byte_cnt is 8 bits and compares against PKT_LEN-1; it never exceeds that value.
- RST asserted mid-packet: the block aborts immediately to reset values. Upstream FIFOs must be reset by the same RST, so no partial packet remains.

Decomposition:
- Shared package/include holds: TS_SYNC=8'h47, NULL_PID=13'h1FFF, NULL_HDR3=8'h10, NULL_FILL=8'hFF, PKT_LEN default, and state encodings ARB/SEND_CH/SEND_NULL.
- One natural sub-module: rr_picker, a combinational round-robin priority search (req vector, pointer -> found, index).

Test Plan:
- Reset then IN_REQ=0, NULL_EN=1 -> after 1 ARB cycle, 188 bytes 47 1F FF 10 FF...; P_SYNC only on byte 0; NULL_PKT=1; IN_RD=0.
- Only ch2 requests, FIFO holds 47 00 21 1x + pattern -> IN_RD[2] high 188 cycles; output equals the FIFO bytes delayed 1 cycle; CH_ID=2; no SYNC_ERR.
- All 4 channels requesting continuously -> CH_ID sequence 0,1,2,3,0 per packet; one D_VALID=0 cycle between packets; no IN_RD overlap.
- NULL_EN=0, no requests -> D_VALID stays 0 indefinitely; raising IN_REQ[1] -> first byte appears 2 cycles later.
- Ch0 first byte 0x00 -> DATA=0x47 on that byte; SYNC_ERR[0] one-cycle pulse aligned with P_SYNC.
- RST low at byte 100 of a ch3 packet -> all outputs 0 asynchronously; after release, the next grant searches from ch0.
